// File: rtl/sm4_pkg.sv
// Shared types for the SM4 request scheduler: widths, FSM state encoding and
// the latched request payload.
package sm4_pkg;

  localparam int unsigned SM4_BLK_W = 128;
  localparam int unsigned SM4_KEY_W = 128;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY   = 3'd1,
    KWAIT = 3'd2,
    DATA  = 3'd3,
    DWAIT = 3'd4,
    RESP  = 3'd5
  } sm4_state_t;

  // One accepted request: direction, key and data block
  typedef struct packed {
    logic                 flag;
    logic [SM4_KEY_W-1:0] key;
    logic [SM4_BLK_W-1:0] din;
  } sm4_req_t;

endpackage

// File: rtl/sm4_sched.sv
// Request scheduler in front of a single sm4_core. Accepts one request at a
// time, reloads the core key only when it differs from the last loaded key,
// drives the core key/data pulses and returns the result over valid/ready.
// Optional watchdog: define SM4_SCHED_TIMEOUT_EN to abort a stalled KWAIT or
// DWAIT after TIMEOUT_CYC cycles and raise the sticky o_err flag.
module sm4_sched
  import sm4_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_flag,
  input  logic [SM4_KEY_W-1:0] i_req_key,
  input  logic [SM4_BLK_W-1:0] i_req_din,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [SM4_BLK_W-1:0] o_rsp_dout,
  output logic                 o_rsp_flag,
  output logic                 o_core_flag,
  output logic [SM4_KEY_W-1:0] o_core_key,
  output logic                 o_core_key_en,
  output logic [SM4_BLK_W-1:0] o_core_din,
  output logic                 o_core_din_en,
  input  logic [SM4_BLK_W-1:0] i_core_dout,
  input  logic                 i_core_dout_en,
  input  logic                 i_core_key_ok,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam longint unsigned WD_SPAN = 64'd1 << CNT_W;

  // Reject a watchdog counter too narrow to reach TIMEOUT_CYC
  if (CNT_W == 0 || TIMEOUT_CYC == 0 || WD_SPAN <= 64'(TIMEOUT_CYC)) begin : g_bad_cfg
    $error("sm4_sched: CNT_W too narrow for TIMEOUT_CYC");
  end

  sm4_state_t           state, state_d;
  sm4_req_t             req_q, req_d;
  logic [SM4_KEY_W-1:0] key_q, key_d;
  logic                 key_vld, key_vld_d;
  logic                 kwait_first, kwait_first_d;

  logic                 req_ready_d;
  logic                 rsp_valid_d;
  logic [SM4_BLK_W-1:0] rsp_dout_d;
  logic                 rsp_flag_d;
  logic                 core_flag_d;
  logic [SM4_KEY_W-1:0] core_key_d;
  logic                 core_key_en_d;
  logic [SM4_BLK_W-1:0] core_din_d;
  logic                 core_din_en_d;
  logic                 busy_d;

`ifdef SM4_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0]     wd_cnt, wd_cnt_d;
  logic                 wd_hit;
  logic                 err_d;
`endif

  // Next-state and next-output logic; every registered output holds by default
  always_comb begin
    state_d       = state;
    req_d         = req_q;
    key_d         = key_q;
    key_vld_d     = key_vld;
    kwait_first_d = kwait_first;
    rsp_valid_d   = o_rsp_valid;
    rsp_dout_d    = o_rsp_dout;
    rsp_flag_d    = o_rsp_flag;
    core_flag_d   = o_core_flag;
    core_key_d    = o_core_key;
    core_key_en_d = 1'b0;
    core_din_d    = o_core_din;
    core_din_en_d = 1'b0;
`ifdef SM4_SCHED_TIMEOUT_EN
    err_d         = o_err;
    wd_hit        = 1'b0;
    wd_cnt_d      = wd_cnt;
`endif

    case (state)
      IDLE: begin
        if (i_req_valid && o_req_ready) begin
          req_d.flag = i_req_flag;
          req_d.key  = i_req_key;
          req_d.din  = i_req_din;
          if (!key_vld || (i_req_key != key_q)) begin
            // Key differs from what the core holds: expand it first
            state_d       = KEY;
            key_vld_d     = 1'b0;
            core_key_d    = i_req_key;
            core_key_en_d = 1'b1;
          end else begin
            // Core already holds this key: issue the block straight away
            state_d       = DATA;
            core_din_d    = i_req_din;
            core_flag_d   = i_req_flag;
            core_din_en_d = 1'b1;
          end
        end
      end

      KEY: begin
        key_d         = req_q.key;
        state_d       = KWAIT;
        kwait_first_d = 1'b1;
      end

      KWAIT: begin
        // key_ok on the first cycle still reflects the previous key
        if (kwait_first) begin
          kwait_first_d = 1'b0;
        end else if (i_core_key_ok) begin
          key_vld_d     = 1'b1;
          state_d       = DATA;
          core_din_d    = req_q.din;
          core_flag_d   = req_q.flag;
          core_din_en_d = 1'b1;
        end
      end

      DATA: begin
        state_d = DWAIT;
      end

      DWAIT: begin
        if (i_core_dout_en) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_dout_d  = i_core_dout;
          rsp_flag_d  = req_q.flag;
        end
      end

      RESP: begin
        if (i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SM4_SCHED_TIMEOUT_EN
    // Abort a wait that made no progress for TIMEOUT_CYC cycles
    wd_hit = ((state == KWAIT) || (state == DWAIT)) && (state_d == state) &&
             (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    if (wd_hit) begin
      state_d       = IDLE;
      key_vld_d     = 1'b0;
      kwait_first_d = 1'b0;
      rsp_valid_d   = 1'b0;
      err_d         = 1'b1;
    end
    if (state_d != state) begin
      wd_cnt_d = '0;
    end else if ((state == KWAIT) || (state == DWAIT)) begin
      wd_cnt_d = wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt_d = '0;
    end
`endif

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Request/key bookkeeping and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q         <= '0;
      key_q         <= '0;
      key_vld       <= 1'b0;
      kwait_first   <= 1'b0;
      o_req_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_dout    <= '0;
      o_rsp_flag    <= 1'b0;
      o_core_flag   <= 1'b0;
      o_core_key    <= '0;
      o_core_key_en <= 1'b0;
      o_core_din    <= '0;
      o_core_din_en <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      req_q         <= req_d;
      key_q         <= key_d;
      key_vld       <= key_vld_d;
      kwait_first   <= kwait_first_d;
      o_req_ready   <= req_ready_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_dout    <= rsp_dout_d;
      o_rsp_flag    <= rsp_flag_d;
      o_core_flag   <= core_flag_d;
      o_core_key    <= core_key_d;
      o_core_key_en <= core_key_en_d;
      o_core_din    <= core_din_d;
      o_core_din_en <= core_din_en_d;
      o_busy        <= busy_d;
    end
  end

`ifdef SM4_SCHED_TIMEOUT_EN
  // Watchdog counter and sticky abort flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_cnt <= '0;
      o_err  <= 1'b0;
    end else begin
      wd_cnt <= wd_cnt_d;
      o_err  <= err_d;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
